// File: rtl/inputs_bank_pkg.sv
// Shared defaults and elaboration-time parameter checks for the double-buffered input bank.
package inputs_bank_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_RD_PORTS = 2;
    localparam int DEF_CNT_W    = 16;

    function automatic bit addr_w_ok(input int addr_w, input int width);
        return addr_w >= $clog2(width);
    endfunction

endpackage

// File: rtl/inputs_bank_rdport.sv
// One registered read port on the active bank; out-of-range addresses raise err_o.
module inputs_bank_rdport
    import inputs_bank_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  act_data_i,
    input  logic [WIDTH-1:0]  act_valid_i,
    output logic              data_o,
    output logic              valid_o,
    output logic              err_o
);

    localparam logic [ADDR_W:0] WIDTH_L = (ADDR_W + 1)'(WIDTH);

    logic data_q, data_d;
    logic valid_q, valid_d;
    logic err_q, err_d;
    logic in_range;

    always_comb begin
        in_range = {1'b0, addr_i} < WIDTH_L;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (rd_en_i) begin
            if (in_range) begin
                data_d  = act_data_i[addr_i];
                valid_d = act_valid_i[addr_i];
            end else begin
                data_d = 1'b0;
                err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: rtl/inputs_bank.sv
// Double-buffered input bit store: shadow bank fed by masked loads and bit writes,
// committed atomically into an active bank served by RD_PORTS registered read ports.
module inputs_bank
    import inputs_bank_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int ADDR_W        = $clog2(WIDTH),
    parameter int RD_PORTS      = DEF_RD_PORTS,
    parameter int CLR_ON_COMMIT = 1,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_input,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [WIDTH-1:0]           CLK_FLAGS,
    input  logic                       in_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic                       val,
    input  logic                       commit,
    input  logic [RD_PORTS-1:0]        rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
    output logic [RD_PORTS-1:0]        out_data,
    output logic [RD_PORTS-1:0]        out_valid,
    output logic [RD_PORTS-1:0]        rd_err,
    output logic                       dirty,
    output logic [CNT_W-1:0]           commit_cnt
);

    localparam logic [ADDR_W:0] WIDTH_L = (ADDR_W + 1)'(WIDTH);

    if (!addr_w_ok(ADDR_W, WIDTH) || WIDTH < 2 || WIDTH > 256 ||
        RD_PORTS < 1 || RD_PORTS > 4) begin : g_param_err
        $error("inputs_bank: illegal WIDTH/ADDR_W/RD_PORTS combination");
    end

    logic [WIDTH-1:0] sh_data_q, sh_data_d;
    logic [WIDTH-1:0] sh_valid_q, sh_valid_d;
    logic [WIDTH-1:0] act_data_q, act_valid_q;
    logic             dirty_q, dirty_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] wr_mask, ld_mask, touch;

    always_comb begin
        wr_mask = '0;
        if (in_en && ({1'b0, wr_addr} < WIDTH_L)) begin
            wr_mask[wr_addr] = 1'b1;
        end
        ld_mask = load_input ? CLK_FLAGS : '0;
        touch   = wr_mask | ld_mask;

        // The bit write overrides the bulk load on its own bit.
        sh_data_d = (sh_data_q & ~touch)
                  | (in_data & ld_mask & ~wr_mask)
                  | ({WIDTH{val}} & wr_mask);

        sh_valid_d = sh_valid_q | touch;
        if (commit && CLR_ON_COMMIT != 0) begin
            sh_valid_d = touch;
        end

        dirty_d = dirty_q;
        if (commit) begin
            dirty_d = 1'b0;
        end
        if (|touch) begin
            dirty_d = 1'b1;
        end

        cnt_d = commit ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_data_q   <= '0;
            sh_valid_q  <= '0;
            act_data_q  <= '0;
            act_valid_q <= '0;
            dirty_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sh_data_q  <= sh_data_d;
            sh_valid_q <= sh_valid_d;
            if (commit) begin
                act_data_q  <= sh_data_q;
                act_valid_q <= sh_valid_q;
            end
            dirty_q <= dirty_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dirty      = dirty_q;
    assign commit_cnt = cnt_q;

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rdport
        inputs_bank_rdport #(
            .WIDTH  (WIDTH),
            .ADDR_W (ADDR_W)
        ) u_rdport (
            .clk         (clk),
            .reset       (reset),
            .rd_en_i     (rd_en[p]),
            .addr_i      (rd_addr[p*ADDR_W +: ADDR_W]),
            .act_data_i  (act_data_q),
            .act_valid_i (act_valid_q),
            .data_o      (out_data[p]),
            .valid_o     (out_valid[p]),
            .err_o       (rd_err[p])
        );
    end

endmodule

// File: tb/tb_inputs_bank.sv
// Bench for inputs_bank: a 32-bit instance (clear-on-commit) and a 20-bit instance
// (valid bits retained), checked against a per-bit behavioural model of both banks.
module tb_inputs_bank;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        ld, en, v, cm;
    logic [31:0] din, flg;
    logic [4:0]  wa;
    logic [1:0]  ren;
    logic [9:0]  ra;
    logic [1:0]  od, ov, re;
    logic        dty;
    logic [15:0] cc;

    logic        ld2, en2, v2, cm2;
    logic [19:0] din2, flg2;
    logic [4:0]  wa2;
    logic [1:0]  ren2;
    logic [9:0]  ra2;
    logic [1:0]  od2, ov2, re2;
    logic        dty2;
    logic [15:0] cc2;

    int checks = 0;
    int errors = 0;

    inputs_bank dut (
        .clk(clk), .reset(rst), .load_input(ld), .in_data(din), .CLK_FLAGS(flg),
        .in_en(en), .wr_addr(wa), .val(v), .commit(cm), .rd_en(ren), .rd_addr(ra),
        .out_data(od), .out_valid(ov), .rd_err(re), .dirty(dty), .commit_cnt(cc)
    );

    inputs_bank #(.WIDTH(20), .CLR_ON_COMMIT(0)) dut20 (
        .clk(clk), .reset(rst), .load_input(ld2), .in_data(din2), .CLK_FLAGS(flg2),
        .in_en(en2), .wr_addr(wa2), .val(v2), .commit(cm2), .rd_en(ren2), .rd_addr(ra2),
        .out_data(od2), .out_valid(ov2), .rd_err(re2), .dirty(dty2), .commit_cnt(cc2)
    );

    // Reference model, index 0 = 32-bit instance, 1 = 20-bit instance.
    bit msd[2][32], msv[2][32], mad[2][32], mav[2][32];
    bit mdirty[2];
    int mcnt[2];
    bit eod[2][2], eov[2][2], ere[2][2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 32; i++) begin
                msd[m][i] = 0; msv[m][i] = 0; mad[m][i] = 0; mav[m][i] = 0;
            end
            mdirty[m] = 0;
            mcnt[m]   = 0;
            for (int p = 0; p < 2; p++) begin
                eod[m][p] = 0; eov[m][p] = 0; ere[m][p] = 0;
            end
        end
    endtask

    task automatic model_step(input int m, input int w, input bit clr, input bit l,
                              input bit [31:0] d, input bit [31:0] f, input bit e,
                              input int a, input bit vv, input bit c,
                              input bit [1:0] r, input bit [9:0] rad);
        bit nd[32];
        bit nv[32];
        bit touched;
        int ap;
        touched = 0;
        for (int p = 0; p < 2; p++) begin
            if (r[p]) begin
                ap = int'(rad[p*5 +: 5]);
                if (ap < w) begin
                    eod[m][p] = mad[m][ap]; eov[m][p] = mav[m][ap]; ere[m][p] = 0;
                end else begin
                    eod[m][p] = 0; eov[m][p] = 0; ere[m][p] = 1;
                end
            end else begin
                eov[m][p] = 0; ere[m][p] = 0;
            end
        end
        for (int i = 0; i < 32; i++) begin
            nd[i] = msd[m][i];
            nv[i] = (c && clr) ? 1'b0 : msv[m][i];
        end
        if (l) begin
            for (int i = 0; i < w; i++) begin
                if (f[i]) begin
                    nd[i] = d[i]; nv[i] = 1; touched = 1;
                end
            end
        end
        if (e && a < w) begin
            nd[a] = vv; nv[a] = 1; touched = 1;
        end
        if (c) begin
            for (int i = 0; i < 32; i++) begin
                mad[m][i] = msd[m][i]; mav[m][i] = msv[m][i];
            end
            mcnt[m]   = (mcnt[m] + 1) % 65536;
            mdirty[m] = 0;
        end
        if (touched) mdirty[m] = 1;
        for (int i = 0; i < 32; i++) begin
            msd[m][i] = nd[i]; msv[m][i] = nv[i];
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            model_step(0, 32, 1'b1, ld, din, flg, en, int'(wa), v, cm, ren, ra);
            model_step(1, 20, 1'b0, ld2, {12'b0, din2}, {12'b0, flg2}, en2, int'(wa2),
                       v2, cm2, ren2, ra2);
        end
    end

    task automatic idle_all();
        ld = 0; en = 0; cm = 0; ren = 0;
        ld2 = 0; en2 = 0; cm2 = 0; ren2 = 0;
    endtask

    // One clock with the given stimulus on instance m, then both instances go idle.
    task automatic cyc(input int m, input bit l, input bit [31:0] d, input bit [31:0] f,
                       input bit e, input bit [4:0] a, input bit vv, input bit c,
                       input bit [1:0] r, input bit [4:0] r0, input bit [4:0] r1);
        if (m == 0) begin
            ld = l; din = d; flg = f; en = e; wa = a; v = vv; cm = c; ren = r; ra = {r1, r0};
        end else begin
            ld2 = l; din2 = d[19:0]; flg2 = f[19:0]; en2 = e; wa2 = a; v2 = vv; cm2 = c;
            ren2 = r; ra2 = {r1, r0};
        end
        @(posedge clk);
        #1;
        idle_all();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({od, ov, re, dty, cc} !== 23'd0) begin
            errors++;
            $display("FAIL reset_main: got %h expected 0", {od, ov, re, dty, cc});
        end
        checks++;
        if ({od2, ov2, re2, dty2, cc2} !== 23'd0) begin
            errors++;
            $display("FAIL reset_w20: got %h expected 0", {od2, ov2, re2, dty2, cc2});
        end
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 5'd5, 5'd0);
        checks++;
        if ({od[0], ov[0], re[0], dty, cc} !== 20'd0) begin
            errors++;
            $display("FAIL reset_read5: got %h expected 0", {od[0], ov[0], re[0], dty, cc});
        end
    endtask

    task automatic test_bulk_load();
        cyc(0, 1, 32'hAAAA_AAAA, 32'h5555_5555, 0, 0, 0, 0, 2'b00, 0, 0);
        checks++;
        if (dty !== 1'b1) begin
            errors++; $display("FAIL bulk_dirty: got %b expected 1", dty);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 5'd1, 5'd0);
        checks++;
        if ({ov[0], dty} !== 2'b01) begin
            errors++; $display("FAIL bulk_precommit: got %b expected 01", {ov[0], dty});
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
        checks++;
        if ({dty, cc} !== {1'b0, 16'd1}) begin
            errors++; $display("FAIL bulk_commit: got %h expected 0001", {dty, cc});
        end
        // Bit 1 is outside the mask (never valid); bit 2 is masked and loaded with 0.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 5'd1, 5'd2);
        checks++;
        if ({od, ov, re} !== 6'b00_10_00) begin
            errors++; $display("FAIL bulk_read: got %b expected 001000", {od, ov, re});
        end
    endtask

    task automatic test_write_wins();
        cyc(0, 1, 32'h0, 32'h0001_0000, 1, 5'd16, 1, 0, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 5'd16, 5'd16);
        checks++;
        if ({od, ov, re, cc} !== {6'b11_11_00, 16'd2}) begin
            errors++;
            $display("FAIL write_wins: got %h expected %h", {od, ov, re, cc}, {6'b11_11_00, 16'd2});
        end
    endtask

    task automatic test_commit_overlap();
        cyc(0, 0, 0, 0, 1, 5'd3, 1, 0, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 1, 5'd3, 0, 1, 2'b01, 5'd3, 0);
        checks++;
        if ({od[0], ov[0], dty, cc} !== {3'b111, 16'd4}) begin
            errors++;
            $display("FAIL overlap_read: got %h expected %h", {od[0], ov[0], dty, cc}, {3'b111, 16'd4});
        end
        // The overlapping commit copied the pre-write shadow, whose valid bit had been cleared.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 5'd3, 0);
        checks++;
        if ({od[0], ov[0], dty} !== 3'b101) begin
            errors++; $display("FAIL overlap_mid: got %b expected 101", {od[0], ov[0], dty});
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 5'd3, 0);
        checks++;
        if ({od[0], ov[0], dty, cc} !== {3'b010, 16'd5}) begin
            errors++;
            $display("FAIL overlap_next: got %h expected %h", {od[0], ov[0], dty, cc}, {3'b010, 16'd5});
        end
    endtask

    task automatic test_out_of_range();
        cyc(1, 1, 32'h10, 32'h10, 0, 0, 0, 0, 2'b00, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 5'd4, 5'd25);
        checks++;
        if ({od2, ov2, re2} !== 6'b01_01_10) begin
            errors++; $display("FAIL oor_read: got %b expected 010110", {od2, ov2, re2});
        end
        cyc(1, 0, 0, 0, 1, 5'd25, 1, 0, 2'b00, 0, 0);
        checks++;
        if (dty2 !== 1'b0) begin
            errors++; $display("FAIL oor_write_ignored: got %b expected 0", dty2);
        end
        // Valid bits are retained in this instance, so a bare commit keeps bit 4 valid.
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 5'd4, 0);
        checks++;
        if ({od2[0], ov2[0], cc2} !== {2'b11, 16'd2}) begin
            errors++;
            $display("FAIL retain_valid: got %h expected %h", {od2[0], ov2[0], cc2}, {2'b11, 16'd2});
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            ld = ($urandom_range(3) == 0); din = $urandom; flg = $urandom;
            en = 1'($urandom); wa = 5'($urandom); v = 1'($urandom);
            cm = ($urandom_range(3) == 0); ren = 2'($urandom); ra = 10'($urandom);
            ld2 = ($urandom_range(3) == 0); din2 = 20'($urandom); flg2 = 20'($urandom);
            en2 = 1'($urandom); wa2 = 5'($urandom); v2 = 1'($urandom);
            cm2 = ($urandom_range(3) == 0); ren2 = 2'($urandom); ra2 = 10'($urandom);
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                checks++;
                if ({od[p], ov[p], re[p]} !== {eod[0][p], eov[0][p], ere[0][p]}) begin
                    errors++;
                    $display("FAIL rand_port%0d iter %0d: got %b expected %b", p, k,
                             {od[p], ov[p], re[p]}, {eod[0][p], eov[0][p], ere[0][p]});
                end
                checks++;
                if ({od2[p], ov2[p], re2[p]} !== {eod[1][p], eov[1][p], ere[1][p]}) begin
                    errors++;
                    $display("FAIL rand_w20_port%0d iter %0d: got %b expected %b", p, k,
                             {od2[p], ov2[p], re2[p]}, {eod[1][p], eov[1][p], ere[1][p]});
                end
            end
            checks++;
            if ({dty, cc} !== {mdirty[0], 16'(mcnt[0])}) begin
                errors++;
                $display("FAIL rand_status iter %0d: got %h expected %h", k,
                         {dty, cc}, {mdirty[0], 16'(mcnt[0])});
            end
            checks++;
            if ({dty2, cc2} !== {mdirty[1], 16'(mcnt[1])}) begin
                errors++;
                $display("FAIL rand_w20_status iter %0d: got %h expected %h", k,
                         {dty2, cc2}, {mdirty[1], 16'(mcnt[1])});
            end
        end
        idle_all();
    endtask

    task automatic test_wrap();
        int n;
        n = 65536 - mcnt[0];
        cm = 1'b1;
        repeat (n - 1) @(posedge clk);
        #1;
        checks++;
        if (cc !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_max: got %h expected ffff", cc);
        end
        @(posedge clk);
        #1;
        cm = 1'b0;
        checks++;
        if (cc !== 16'h0000) begin
            errors++; $display("FAIL wrap_zero: got %h expected 0000", cc);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 5'd0, 5'd1);
        checks++;
        if ({od, ov, cc} !== {4'b1111, 16'd1}) begin
            errors++; $display("FAIL premid_state: got %h expected %h", {od, ov, cc}, {4'b1111, 16'd1});
        end
        ld = 1; din = '1; flg = '1; en = 1; wa = 5'd7; v = 1; cm = 1; ren = 2'b11;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({od, ov, re, dty, cc} !== 23'd0) begin
            errors++; $display("FAIL reset_mid: got %h expected 0", {od, ov, re, dty, cc});
        end
        @(posedge clk);
        #1;
        idle_all();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 5'd0, 0);
        checks++;
        if ({od[0], ov[0], dty, cc} !== {3'b000, 16'd1}) begin
            errors++;
            $display("FAIL post_reset_bank: got %h expected %h", {od[0], ov[0], dty, cc}, {3'b000, 16'd1});
        end
    endtask

    initial begin
        din = 0; flg = 0; wa = 0; v = 0; ra = 0;
        din2 = 0; flg2 = 0; wa2 = 0; v2 = 0; ra2 = 0;
        idle_all();
        test_reset();
        test_bulk_load();
        test_write_wins();
        test_commit_overlap();
        test_out_of_range();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
